// File: rtl/accumulate_host.sv
// Host sequencer for the array-accumulate kernel: it loads the array, starts the kernel and captures the result.
// The optional array readback stream is built only when ACCUMULATE_HOST_READBACK_EN is defined.
module accumulate_host #(
   parameter int DEPTH  = 1000,
   parameter int ADDR_W = 10,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              r_enable,
   input  logic [DATA_W-1:0] cfg_init_i,
   input  logic [DATA_W-1:0] cfg_init_acc,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              acc_r_enable,
   output logic [DATA_W-1:0] acc_init_i,
   output logic [DATA_W-1:0] acc_init_acc,
   input  logic              acc_w_enable,
   input  logic [DATA_W-1:0] acc_result,
   output logic              controlArr,
   output logic              controlArrWEnable_a,
   output logic [ADDR_W-1:0] controlArrAddr_a,
   output logic [DATA_W-1:0] controlArrWData_a,
   input  logic [DATA_W-1:0] controlArrRData_a,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              done,
   output logic [DATA_W-1:0] result
);

   typedef enum logic [2:0] {
      ST_LOAD  = 3'd0,
      ST_START = 3'd1,
      ST_RUN   = 3'd2,
`ifdef ACCUMULATE_HOST_READBACK_EN
      ST_DRAIN = 3'd3,
`endif
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              done_q, done_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic [DATA_W-1:0] acc_init_i_q, acc_init_i_d;
   logic [DATA_W-1:0] acc_init_acc_q, acc_init_acc_d;

   always_comb begin
      state_d             = state_q;
      addr_d              = addr_q;
      done_d              = done_q;
      result_d            = result_q;
      acc_init_i_d        = acc_init_i_q;
      acc_init_acc_d      = acc_init_acc_q;
      in_ready            = 1'b0;
      acc_r_enable        = 1'b0;
      controlArr          = 1'b1;
      controlArrWEnable_a = 1'b0;
      controlArrAddr_a    = addr_q;
      controlArrWData_a   = in_data;
      out_valid           = 1'b0;
      out_data            = '0;
      out_last            = 1'b0;

      case (state_q)
         ST_LOAD: begin
            in_ready            = 1'b1;
            controlArrWEnable_a = in_valid;
            if (in_valid) begin
               if (addr_q == LAST_ADDR) begin
                  addr_d  = '0;
                  state_d = ST_START;
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
               end
            end
         end
         ST_START: begin
            acc_r_enable = 1'b1;
            controlArr   = 1'b0;
            state_d      = ST_RUN;
         end
         ST_RUN: begin
            controlArr = 1'b0;
            if (acc_w_enable) begin
               result_d = acc_result;
`ifdef ACCUMULATE_HOST_READBACK_EN
               state_d  = ST_DRAIN;
`else
               state_d  = ST_DONE;
               done_d   = 1'b1;
`endif
            end
         end
`ifdef ACCUMULATE_HOST_READBACK_EN
         // The array read port is combinational, so the word is valid in the same cycle as its address.
         ST_DRAIN: begin
            out_valid = 1'b1;
            out_data  = controlArrRData_a;
            out_last  = (addr_q == LAST_ADDR);
            if (out_ready) begin
               if (addr_q == LAST_ADDR) begin
                  addr_d  = '0;
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
               end
            end
         end
`endif
         ST_DONE: begin
            done_d = 1'b1;
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

`ifndef ACCUMULATE_HOST_READBACK_EN
   logic unused_readback;
   assign unused_readback = out_ready ^ (^controlArrRData_a);
`endif

   always_ff @(posedge clk) begin
      if (r_enable) begin
         state_q        <= ST_LOAD;
         addr_q         <= '0;
         done_q         <= 1'b0;
         result_q       <= '0;
         acc_init_i_q   <= cfg_init_i;
         acc_init_acc_q <= cfg_init_acc;
      end else begin
         state_q        <= state_d;
         addr_q         <= addr_d;
         done_q         <= done_d;
         result_q       <= result_d;
         acc_init_i_q   <= acc_init_i_d;
         acc_init_acc_q <= acc_init_acc_d;
      end
   end

   assign done         = done_q;
   assign result       = result_q;
   assign acc_init_i   = acc_init_i_q;
   assign acc_init_acc = acc_init_acc_q;

endmodule

// File: tb/tb_accumulate_host.sv
// Testbench for accumulate_host with a behavioural model of the accumulate kernel attached.
// The readback checks are compiled in when ACCUMULATE_HOST_READBACK_EN is defined.
module tb_accumulate_host;

   localparam int DEPTH  = 1000;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 64;

   logic              clk;
   logic              r_enable;
   logic [DATA_W-1:0] cfg_init_i;
   logic [DATA_W-1:0] cfg_init_acc;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              acc_r_enable;
   logic [DATA_W-1:0] acc_init_i;
   logic [DATA_W-1:0] acc_init_acc;
   logic              acc_w_enable;
   logic [DATA_W-1:0] acc_result;
   logic              controlArr;
   logic              controlArrWEnable_a;
   logic [ADDR_W-1:0] controlArrAddr_a;
   logic [DATA_W-1:0] controlArrWData_a;
   logic [DATA_W-1:0] controlArrRData_a;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              done;
   logic [DATA_W-1:0] result;

   int vectorCount   = 0;
   int miscompares   = 0;
   logic kernelStall = 1'b0;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } writeExp_t;

   writeExp_t         writeQueue[$];
   logic [DATA_W-1:0] readQueue[$];

   accumulate_host #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk                 (clk),
      .r_enable            (r_enable),
      .cfg_init_i          (cfg_init_i),
      .cfg_init_acc        (cfg_init_acc),
      .in_valid            (in_valid),
      .in_ready            (in_ready),
      .in_data             (in_data),
      .acc_r_enable        (acc_r_enable),
      .acc_init_i          (acc_init_i),
      .acc_init_acc        (acc_init_acc),
      .acc_w_enable        (acc_w_enable),
      .acc_result          (acc_result),
      .controlArr          (controlArr),
      .controlArrWEnable_a (controlArrWEnable_a),
      .controlArrAddr_a    (controlArrAddr_a),
      .controlArrWData_a   (controlArrWData_a),
      .controlArrRData_a   (controlArrRData_a),
      .out_valid           (out_valid),
      .out_ready           (out_ready),
      .out_data            (out_data),
      .out_last            (out_last),
      .done                (done),
      .result              (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Kernel model: one element per cycle, arr[i] = acc += arr[i], then w_enable with the final accumulator.
   logic [DATA_W-1:0] kMem [0:DEPTH-1];
   logic [DATA_W-1:0] kIdx;
   logic [DATA_W-1:0] kAcc;
   logic [DATA_W-1:0] kResult;
   logic              kBusy = 1'b0;
   logic              kWen  = 1'b0;

   assign acc_w_enable      = kWen;
   assign acc_result        = kWen ? kResult : 64'hDEAD_BEEF_0BAD_F00D;
   assign controlArrRData_a = (int'(controlArrAddr_a) < DEPTH) ? kMem[controlArrAddr_a] : '0;

   always @(posedge clk) begin
      if (controlArr && controlArrWEnable_a && (int'(controlArrAddr_a) < DEPTH))
         kMem[controlArrAddr_a] <= controlArrWData_a;
      if (acc_r_enable) begin
         kBusy <= 1'b1;
         kWen  <= 1'b0;
         kIdx  <= acc_init_i;
         kAcc  <= acc_init_acc;
      end else if (kBusy && !kernelStall) begin
         if (kIdx < 64'(DEPTH)) begin
            kAcc <= kAcc + kMem[kIdx[ADDR_W-1:0]];
            if (!controlArr)
               kMem[kIdx[ADDR_W-1:0]] <= kAcc + kMem[kIdx[ADDR_W-1:0]];
            kIdx <= kIdx + 64'd1;
         end else begin
            kBusy   <= 1'b0;
            kWen    <= 1'b1;
            kResult <= kAcc;
         end
      end
   end

   // Expected array word after a run over an all-ones array.
   function automatic logic [DATA_W-1:0] expWord(input int k, input int initI, input int initAcc);
      if (k < initI) return 64'd1;
      return 64'(initAcc + (k - initI + 1));
   endfunction

   task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                              input logic [DATA_W-1:0] expected);
      vectorCount++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Called at a negedge; applies reset for one edge and checks the post-reset state.
   task automatic applyStimulus(input int initI, input int initAcc);
      r_enable     = 1'b1;
      cfg_init_i   = 64'(initI);
      cfg_init_acc = 64'(initAcc);
      in_valid     = 1'b0;
      @(negedge clk);
      r_enable = 1'b0;
      #1;
      checkOutput("rst_done", 64'(done), 64'd0);
      checkOutput("rst_result", result, 64'd0);
      checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
      checkOutput("rst_ctrl", 64'(controlArr), 64'd1);
      checkOutput("rst_init_i", acc_init_i, 64'(initI));
      checkOutput("rst_init_acc", acc_init_acc, 64'(initAcc));
   endtask

   task automatic loadArray(input int numWords, input bit toggle);
      int sent = 0;
      int cyc  = 0;
      writeExp_t got;
      while (sent < numWords) begin
         in_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
         in_data  = 64'd1;
         if (in_valid) writeQueue.push_back('{addr: ADDR_W'(sent), data: 64'd1});
         #1;
         checkOutput("load_in_ready", 64'(in_ready), 64'd1);
         checkOutput("load_we", 64'(controlArrWEnable_a), 64'(in_valid));
`ifndef ACCUMULATE_HOST_READBACK_EN
         checkOutput("load_out_valid", 64'(out_valid), 64'd0);
`endif
         if (controlArrWEnable_a && writeQueue.size() > 0) begin
            got = writeQueue.pop_front();
            checkOutput("load_addr", 64'(controlArrAddr_a), 64'(got.addr));
            checkOutput("load_wdata", controlArrWData_a, got.data);
         end
         if (in_valid) sent++;
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
   endtask

   // Entered at the negedge after the final load; checks START, waits for the kernel and checks the result.
   task automatic runKernel(input int initI, input int initAcc);
      int cycles = 0;
      int pulses = 0;
      bit seen   = 0;
      #1;
      checkOutput("start_pulse", 64'(acc_r_enable), 64'd1);
      checkOutput("start_ctrl", 64'(controlArr), 64'd0);
      checkOutput("start_in_ready", 64'(in_ready), 64'd0);
      checkOutput("start_we", 64'(controlArrWEnable_a), 64'd0);
      for (int k = 0; k < DEPTH; k++) readQueue.push_back(expWord(k, initI, initAcc));
      @(negedge clk);
      checkOutput("run_ctrl", 64'(controlArr), 64'd0);
      while (!seen && cycles < 3000) begin
         if (acc_r_enable) pulses++;
`ifndef ACCUMULATE_HOST_READBACK_EN
         if (out_valid) pulses++;
`endif
         if (acc_w_enable) seen = 1;
         else begin
            @(negedge clk);
            cycles++;
         end
      end
      checkOutput("run_wen_seen", 64'(seen), 64'd1);
      checkOutput("run_stray_pulses", 64'(pulses), 64'd0);
      @(negedge clk);
      checkOutput("run_result", result, 64'(initAcc + (DEPTH - initI)));
`ifndef ACCUMULATE_HOST_READBACK_EN
      checkOutput("done_after_capture", 64'(done), 64'd1);
      checkOutput("done_out_valid", 64'(out_valid), 64'd0);
      readQueue.delete();
`endif
      checkOutput("kmem_0", kMem[0], expWord(0, initI, initAcc));
      checkOutput("kmem_500", kMem[500], expWord(500, initI, initAcc));
      checkOutput("kmem_999", kMem[999], expWord(999, initI, initAcc));
   endtask

`ifdef ACCUMULATE_HOST_READBACK_EN
   task automatic drainArray(input bit stallAt7);
      logic [DATA_W-1:0] expected;
      for (int k = 0; k < DEPTH; k++) begin
         expected = readQueue.pop_front();
         if (stallAt7 && k == 7) begin
            for (int s = 0; s < 3; s++) begin
               out_ready = 1'b0;
               #1;
               checkOutput("stall_valid", 64'(out_valid), 64'd1);
               checkOutput("stall_data", out_data, expected);
               @(negedge clk);
            end
         end
         out_ready = 1'b1;
         #1;
         checkOutput("drain_valid", 64'(out_valid), 64'd1);
         checkOutput("drain_data", out_data, expected);
         checkOutput("drain_last", 64'(out_last), 64'(k == DEPTH - 1));
         checkOutput("drain_done", 64'(done), 64'd0);
         @(negedge clk);
      end
      #1;
      checkOutput("final_done", 64'(done), 64'd1);
      checkOutput("final_out_valid", 64'(out_valid), 64'd0);
   endtask
`endif

   task automatic fullRun(input int initI, input int initAcc, input bit toggle, input bit stallAt7);
      loadArray(DEPTH, toggle);
      runKernel(initI, initAcc);
`ifdef ACCUMULATE_HOST_READBACK_EN
      drainArray(stallAt7);
`else
      if (stallAt7) checkOutput("idle_out_valid", 64'(out_valid), 64'd0);
`endif
      #1;
      checkOutput("end_done", 64'(done), 64'd1);
      checkOutput("end_in_ready", 64'(in_ready), 64'd0);
      checkOutput("end_ctrl", 64'(controlArr), 64'd1);
   endtask

   initial begin
      r_enable     = 1'b1;
      cfg_init_i   = '0;
      cfg_init_acc = '0;
      in_valid     = 1'b0;
      in_data      = '0;
      out_ready    = 1'b1;
      @(negedge clk);

      applyStimulus(0, 0);
      fullRun(0, 0, 1'b0, 1'b0);

      applyStimulus(500, 10);
      fullRun(500, 10, 1'b0, 1'b0);

      applyStimulus(0, 0);
      fullRun(0, 0, 1'b1, 1'b1);

      // Abort a load part-way; the next load must restart from address 0.
      applyStimulus(0, 0);
      loadArray(300, 1'b0);
      applyStimulus(0, 0);
      fullRun(0, 0, 1'b0, 1'b0);

      // Kernel never finishes: the host must sit in RUN indefinitely.
      kernelStall = 1'b1;
      applyStimulus(0, 0);
      loadArray(DEPTH, 1'b0);
      @(negedge clk);
      for (int c = 0; c < 50000; c++) begin
         checkOutput("hold_done", 64'(done), 64'd0);
         checkOutput("hold_ctrl", 64'(controlArr), 64'd0);
         @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompares);
      $finish;
   end

endmodule
